// File: rtl/matmul_chk_pkg.sv
// Shared types and helpers for the matmul stream checker.
// Optional first-miss trace capture is enabled by defining MATMUL_CHK_TRACE_EN.
package matmul_chk_pkg;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_ELEM  = 2'd1,
    CHK_FLAGS = 2'd2,
    CHK_DONE  = 2'd3
  } chk_state_e;

  localparam int unsigned MASK_W = 64;

  // Largest matrix dimension whose operands pack into one bus word.
  function automatic int unsigned max_dim(input int unsigned bus_w, input int unsigned data_w);
    return bus_w / data_w;
  endfunction

  // Flags word carries one bit per (i,j) at bit i*md+j; only the active dim x dim corner counts.
  function automatic logic [MASK_W-1:0] flag_mask(input int unsigned dim, input int unsigned md);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        if ((i < dim) && (j < dim) && (i < md) && (j < md) && ((i * md + j) < MASK_W)) begin
          m[6'(i * md + j)] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/matmul_chk_fifo.sv
// Synchronous expected-value FIFO with count-based, registered ready/empty flags.
// Push while full is honoured when a pop happens in the same cycle.
module matmul_chk_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_c_o,
  output logic             ready_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic             empty_q, empty_d;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign pop_ok_c    = pop_i && !empty_q;
  assign push_ok_c   = push_i && (ready_q || pop_ok_c);
  assign rd_data_c_o = mem_q[rd_ptr_q];
  assign ready_o     = ready_q;
  assign empty_o     = empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_c) begin
      wr_ptr_d = AW'(wr_ptr_q + AW'(1));
    end
    if (pop_ok_c) begin
      rd_ptr_d = AW'(rd_ptr_q + AW'(1));
    end
    count_d = CW'(count_q + CW'(push_ok_c) - CW'(pop_ok_c));
    ready_d = (count_d != CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/matmul_stream_checker.sv
// Scoreboard comparing matmul C-matrix read-back and flags word against queued expected values.
// Define MATMUL_CHK_TRACE_EN to capture the first missed expected/observed pair of each run.
module matmul_stream_checker
  import matmul_chk_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned EXP_DEPTH  = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  localparam int unsigned MAX_DIM = max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int unsigned DIM_W   = $clog2(MAX_DIM + 1),
  localparam int unsigned IDX_W   = $clog2(MAX_DIM * MAX_DIM + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DIM_W-1:0]     dim_i,
  input  logic                 exp_valid_i,
  input  logic [BUS_WIDTH-1:0] exp_data_i,
  output logic                 exp_ready_o,
  input  logic                 obs_valid_i,
  input  logic [BUS_WIDTH-1:0] obs_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mismatch_o,
  output logic [IDX_W-1:0]     mismatch_idx_o,
  output logic                 underflow_o,
  output logic [CNT_WIDTH-1:0] run_hits_o,
  output logic [CNT_WIDTH-1:0] run_checks_o,
  output logic [CNT_WIDTH-1:0] tot_hits_o,
  output logic [CNT_WIDTH-1:0] tot_checks_o,
  output logic [CNT_WIDTH-1:0] flag_hits_o,
  output logic [CNT_WIDTH-1:0] flag_checks_o,
  output logic [BUS_WIDTH-1:0] first_miss_exp_o,
  output logic [BUS_WIDTH-1:0] first_miss_obs_o,
  output logic                 first_miss_vld_o
);

  localparam logic [1:0] ST_IDLE  = CHK_IDLE;
  localparam logic [1:0] ST_ELEM  = CHK_ELEM;
  localparam logic [1:0] ST_FLAGS = CHK_FLAGS;
  localparam logic [1:0] ST_DONE  = CHK_DONE;

  logic [1:0]           state_q, state_d;
  logic [DIM_W-1:0]     dim_q, dim_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 mismatch_q, mismatch_d;
  logic [IDX_W-1:0]     mismatch_idx_q, mismatch_idx_d;
  logic                 underflow_q, underflow_d;
  logic [CNT_WIDTH-1:0] run_hits_q, run_hits_d;
  logic [CNT_WIDTH-1:0] run_checks_q, run_checks_d;
  logic [CNT_WIDTH-1:0] tot_hits_q, tot_hits_d;
  logic [CNT_WIDTH-1:0] tot_checks_q, tot_checks_d;
  logic [CNT_WIDTH-1:0] flag_hits_q, flag_hits_d;
  logic [CNT_WIDTH-1:0] flag_checks_q, flag_checks_d;

  logic [BUS_WIDTH-1:0] fifo_rd_data_c;
  logic                 fifo_ready_c;
  logic                 fifo_empty_c;
  logic                 cmp_ev_c;
  logic                 hit_c;
  logic                 elem_eq_c;
  logic                 flag_eq_c;
  logic                 start_ok_c;
  logic [BUS_WIDTH-1:0] mask_c;
  logic [DIM_W-1:0]     dim_clamp_c;
  logic [IDX_W-1:0]     n_elem_c;
  logic [IDX_W-1:0]     idx_inc_c;

  matmul_chk_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (EXP_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (exp_valid_i && fifo_ready_c),
    .data_i      (exp_data_i),
    .pop_i       (cmp_ev_c && !fifo_empty_c),
    .rd_data_c_o (fifo_rd_data_c),
    .ready_o     (fifo_ready_c),
    .empty_o     (fifo_empty_c)
  );

  assign start_ok_c  = start_i && (state_q == ST_IDLE);
  assign cmp_ev_c    = obs_valid_i && ((state_q == ST_ELEM) || (state_q == ST_FLAGS));
  assign dim_clamp_c = ((dim_i == '0) || (32'(dim_i) > MAX_DIM)) ? DIM_W'(MAX_DIM) : dim_i;
  assign n_elem_c    = IDX_W'(32'(dim_q) * 32'(dim_q));
  assign idx_inc_c   = IDX_W'(idx_q + IDX_W'(1));
  assign mask_c      = BUS_WIDTH'(flag_mask(32'(dim_q), MAX_DIM));
  assign elem_eq_c   = ($signed(fifo_rd_data_c) == $signed(obs_data_i));
  assign flag_eq_c   = (((fifo_rd_data_c ^ obs_data_i) & mask_c) == '0);
  // An empty FIFO at a compare is always a miss.
  assign hit_c       = !fifo_empty_c && ((state_q == ST_ELEM) ? elem_eq_c : flag_eq_c);

  // Next-state, counters and result pulses.
  always_comb begin
    state_d        = state_q;
    dim_d          = dim_q;
    idx_d          = idx_q;
    mismatch_d     = 1'b0;
    mismatch_idx_d = mismatch_idx_q;
    underflow_d    = underflow_q;
    run_hits_d     = run_hits_q;
    run_checks_d   = run_checks_q;
    tot_hits_d     = tot_hits_q;
    tot_checks_d   = tot_checks_q;
    flag_hits_d    = flag_hits_q;
    flag_checks_d  = flag_checks_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d      = ST_ELEM;
          dim_d        = dim_clamp_c;
          idx_d        = '0;
          run_hits_d   = '0;
          run_checks_d = '0;
        end
      end
      ST_ELEM: begin
        if (cmp_ev_c) begin
          idx_d        = idx_inc_c;
          run_checks_d = CNT_WIDTH'(sat_inc(64'(run_checks_q), CNT_WIDTH));
          tot_checks_d = CNT_WIDTH'(sat_inc(64'(tot_checks_q), CNT_WIDTH));
          if (hit_c) begin
            run_hits_d = CNT_WIDTH'(sat_inc(64'(run_hits_q), CNT_WIDTH));
            tot_hits_d = CNT_WIDTH'(sat_inc(64'(tot_hits_q), CNT_WIDTH));
          end
          if (idx_inc_c == n_elem_c) begin
            state_d = ST_FLAGS;
          end
        end
      end
      ST_FLAGS: begin
        if (cmp_ev_c) begin
          state_d       = ST_DONE;
          flag_checks_d = CNT_WIDTH'(sat_inc(64'(flag_checks_q), CNT_WIDTH));
          if (hit_c) begin
            flag_hits_d = CNT_WIDTH'(sat_inc(64'(flag_hits_q), CNT_WIDTH));
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cmp_ev_c) begin
      if (fifo_empty_c) begin
        underflow_d = 1'b1;
      end
      if (!hit_c) begin
        mismatch_d     = 1'b1;
        mismatch_idx_d = idx_q;
      end
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      dim_q          <= DIM_W'(MAX_DIM);
      idx_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mismatch_q     <= 1'b0;
      mismatch_idx_q <= '0;
      underflow_q    <= 1'b0;
      run_hits_q     <= '0;
      run_checks_q   <= '0;
      tot_hits_q     <= '0;
      tot_checks_q   <= '0;
      flag_hits_q    <= '0;
      flag_checks_q  <= '0;
    end else begin
      state_q        <= state_d;
      dim_q          <= dim_d;
      idx_q          <= idx_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mismatch_q     <= mismatch_d;
      mismatch_idx_q <= mismatch_idx_d;
      underflow_q    <= underflow_d;
      run_hits_q     <= run_hits_d;
      run_checks_q   <= run_checks_d;
      tot_hits_q     <= tot_hits_d;
      tot_checks_q   <= tot_checks_d;
      flag_hits_q    <= flag_hits_d;
      flag_checks_q  <= flag_checks_d;
    end
  end

  assign exp_ready_o    = fifo_ready_c;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mismatch_o     = mismatch_q;
  assign mismatch_idx_o = mismatch_idx_q;
  assign underflow_o    = underflow_q;
  assign run_hits_o     = run_hits_q;
  assign run_checks_o   = run_checks_q;
  assign tot_hits_o     = tot_hits_q;
  assign tot_checks_o   = tot_checks_q;
  assign flag_hits_o    = flag_hits_q;
  assign flag_checks_o  = flag_checks_q;

`ifdef MATMUL_CHK_TRACE_EN
  logic [BUS_WIDTH-1:0] fm_exp_q, fm_exp_d;
  logic [BUS_WIDTH-1:0] fm_obs_q, fm_obs_d;
  logic                 fm_vld_q, fm_vld_d;

  // First miss of a run is held until the next accepted start.
  always_comb begin
    fm_exp_d = fm_exp_q;
    fm_obs_d = fm_obs_q;
    fm_vld_d = fm_vld_q;
    if (start_ok_c) begin
      fm_exp_d = '0;
      fm_obs_d = '0;
      fm_vld_d = 1'b0;
    end else if (cmp_ev_c && !hit_c && !fm_vld_q) begin
      fm_exp_d = fifo_empty_c ? '0 : fifo_rd_data_c;
      fm_obs_d = obs_data_i;
      fm_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fm_exp_q <= '0;
      fm_obs_q <= '0;
      fm_vld_q <= 1'b0;
    end else begin
      fm_exp_q <= fm_exp_d;
      fm_obs_q <= fm_obs_d;
      fm_vld_q <= fm_vld_d;
    end
  end

  assign first_miss_exp_o = fm_exp_q;
  assign first_miss_obs_o = fm_obs_q;
  assign first_miss_vld_o = fm_vld_q;
`else
  logic unused_start_ok;
  assign unused_start_ok  = start_ok_c;
  assign first_miss_exp_o = '0;
  assign first_miss_obs_o = '0;
  assign first_miss_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_stream_checker.sv
// Directed self-checking bench for matmul_stream_checker (default build, 4x4 max, 32-deep FIFO).
module tb_matmul_stream_checker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  dim_i;
  logic        exp_valid_i;
  logic [31:0] exp_data_i;
  logic        exp_ready_o;
  logic        obs_valid_i;
  logic [31:0] obs_data_i;
  logic        busy_o;
  logic        done_o;
  logic        mismatch_o;
  logic [4:0]  mismatch_idx_o;
  logic        underflow_o;
  logic [31:0] run_hits_o, run_checks_o, tot_hits_o, tot_checks_o, flag_hits_o, flag_checks_o;
  logic [31:0] first_miss_exp_o, first_miss_obs_o;
  logic        first_miss_vld_o;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int miss_cnt = 0;
  int d0, m0;
  logic [31:0] ew [32];
  logic [31:0] ow [32];

  matmul_stream_checker dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .dim_i            (dim_i),
    .exp_valid_i      (exp_valid_i),
    .exp_data_i       (exp_data_i),
    .exp_ready_o      (exp_ready_o),
    .obs_valid_i      (obs_valid_i),
    .obs_data_i       (obs_data_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .mismatch_o       (mismatch_o),
    .mismatch_idx_o   (mismatch_idx_o),
    .underflow_o      (underflow_o),
    .run_hits_o       (run_hits_o),
    .run_checks_o     (run_checks_o),
    .tot_hits_o       (tot_hits_o),
    .tot_checks_o     (tot_checks_o),
    .flag_hits_o      (flag_hits_o),
    .flag_checks_o    (flag_checks_o),
    .first_miss_exp_o (first_miss_exp_o),
    .first_miss_obs_o (first_miss_obs_o),
    .first_miss_vld_o (first_miss_vld_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (mismatch_o) miss_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    int guard;
    guard = 0;
    while (!exp_ready_o && guard < 64) begin
      @(negedge clk_i);
      guard++;
    end
    if (!exp_ready_o) check("push_ready_timeout", 32'(exp_ready_o), 32'd1);
    exp_valid_i = 1'b1;
    exp_data_i  = w;
    @(negedge clk_i);
    exp_valid_i = 1'b0;
  endtask

  task automatic obs_word(input logic [31:0] w);
    obs_valid_i = 1'b1;
    obs_data_i  = w;
    @(negedge clk_i);
    obs_valid_i = 1'b0;
  endtask

  task automatic start_run(input logic [2:0] d);
    start_i = 1'b1;
    dim_i   = d;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) push_word(ew[i]);
  endtask

  task automatic obs_n(input int n);
    for (int i = 0; i < n; i++) obs_word(ow[i]);
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (busy_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    check(tag, 32'(busy_o), 32'd0);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // 1..16 elements plus flags 0xA5, observed identically.
  task automatic load_clean4();
    for (int i = 0; i < 16; i++) begin
      ew[i] = 32'(i + 1);
      ow[i] = 32'(i + 1);
    end
    ew[16] = 32'h0000_00A5;
    ow[16] = 32'h0000_00A5;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; dim_i = 3'd0;
    exp_valid_i = 1'b0; exp_data_i = '0; obs_valid_i = 1'b0; obs_data_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(exp_ready_o), 32'd1);
    check("rst_underflow", 32'(underflow_o), 32'd0);
    check("rst_tot_checks", tot_checks_o, 32'd0);
    check("rst_flag_checks", flag_checks_o, 32'd0);

    // Test 1: clean dim=4
    load_clean4();
    d0 = done_cnt; m0 = miss_cnt;
    push_n(17);
    start_run(3'd4);
    check("t1_busy", 32'(busy_o), 32'd1);
    obs_n(17);
    wait_idle("t1_idle");
    check("t1_run_hits", run_hits_o, 32'd16);
    check("t1_run_checks", run_checks_o, 32'd16);
    check("t1_flag_hits", flag_hits_o, 32'd1);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t1_mismatches", 32'(miss_cnt - m0), 32'd0);

    // Test 2: element 5 observed as -3 instead of 6
    load_clean4();
    ow[5] = 32'hFFFF_FFFD;
    m0 = miss_cnt;
    push_n(17);
    start_run(3'd4);
    obs_n(17);
    wait_idle("t2_idle");
    check("t2_run_hits", run_hits_o, 32'd15);
    check("t2_run_checks", run_checks_o, 32'd16);
    check("t2_mismatches", 32'(miss_cnt - m0), 32'd1);
    check("t2_miss_idx", 32'(mismatch_idx_o), 32'd5);
    check("t2_tot_hits", tot_hits_o, 32'd31);

    // Test 3: dim=2 masked flags
    ew[0] = 32'd10; ew[1] = 32'hFFFF_FFEC; ew[2] = 32'd30; ew[3] = 32'hFFFF_FFD8;
    ew[4] = 32'h0000_0033;
    for (int i = 0; i < 4; i++) ow[i] = ew[i];
    ow[4] = 32'h0000_FF33;
    m0 = miss_cnt;
    push_n(5);
    start_run(3'd2);
    obs_n(5);
    wait_idle("t3a_idle");
    check("t3a_run_hits", run_hits_o, 32'd4);
    check("t3a_flag_hits", flag_hits_o, 32'd3);
    check("t3a_mismatches", 32'(miss_cnt - m0), 32'd0);
    ow[4] = 32'h0000_0031;
    push_n(5);
    start_run(3'd2);
    obs_n(5);
    wait_idle("t3b_idle");
    check("t3b_flag_hits", flag_hits_o, 32'd3);
    check("t3b_flag_checks", flag_checks_o, 32'd4);
    check("t3b_miss_idx", 32'(mismatch_idx_o), 32'd4);
    check("t3b_mismatches", 32'(miss_cnt - m0), 32'd1);
    check("t3b_tot_checks", tot_checks_o, 32'd40);

    // Test 4: fill to full, 33rd word held until a pop, then drain into underflow
    for (int i = 0; i < 32; i++) push_word(32'(100 + i));
    check("t4_ready_full", 32'(exp_ready_o), 32'd0);
    exp_valid_i = 1'b1;
    exp_data_i  = 32'd999;
    repeat (3) @(negedge clk_i);
    check("t4_ready_held", 32'(exp_ready_o), 32'd0);
    start_run(3'd4);
    obs_word(32'd100);
    check("t4_ready_after_pop", 32'(exp_ready_o), 32'd1);
    @(negedge clk_i);
    exp_valid_i = 1'b0;
    for (int i = 1; i < 17; i++) obs_word(32'(100 + i));
    wait_idle("t4a_idle");
    check("t4a_run_hits", run_hits_o, 32'd16);
    check("t4a_flag_hits", flag_hits_o, 32'd4);
    start_run(3'd3);
    for (int i = 0; i < 10; i++) obs_word(32'(117 + i));
    wait_idle("t4b_idle");
    check("t4b_run_hits", run_hits_o, 32'd9);
    check("t4b_flag_hits", flag_hits_o, 32'd5);
    check("t4b_underflow", 32'(underflow_o), 32'd0);
    m0 = miss_cnt;
    start_run(3'd3);
    for (int i = 0; i < 5; i++) obs_word(32'(127 + i));
    obs_word(32'd999);
    check("t4c_hits_before_empty", run_hits_o, 32'd6);
    obs_word(32'd0);
    check("t4c_underflow", 32'(underflow_o), 32'd1);
    obs_word(32'd0);
    obs_word(32'd0);
    obs_word(32'd0);
    wait_idle("t4c_idle");
    check("t4c_run_hits", run_hits_o, 32'd6);
    check("t4c_run_checks", run_checks_o, 32'd9);
    check("t4c_flag_checks", flag_checks_o, 32'd7);
    check("t4c_mismatches", 32'(miss_cnt - m0), 32'd4);
    check("t4c_miss_idx", 32'(mismatch_idx_o), 32'd9);
    check("t4c_tot_checks", tot_checks_o, 32'd74);

    // Test 5: reset after 7 compares
    start_run(3'd4);
    for (int i = 0; i < 10; i++) push_word(32'(200 + i));
    for (int i = 0; i < 7; i++) obs_word(32'(200 + i));
    check("t5_run_checks_pre", run_checks_o, 32'd7);
    do_reset();
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_run_checks", run_checks_o, 32'd0);
    check("t5_tot_hits", tot_hits_o, 32'd0);
    check("t5_flag_checks", flag_checks_o, 32'd0);
    check("t5_underflow", 32'(underflow_o), 32'd0);
    check("t5_ready", 32'(exp_ready_o), 32'd1);
    start_run(3'd1);
    obs_word(32'd200);
    check("t5_flushed_underflow", 32'(underflow_o), 32'd1);
    check("t5_flushed_hits", run_hits_o, 32'd0);
    obs_word(32'd0);
    wait_idle("t5_idle");
    check("t5_dim1_checks", run_checks_o, 32'd1);
    do_reset();

    // Test 6: two clean runs, dim=0 clamps to 4, start while busy ignored
    load_clean4();
    d0 = done_cnt;
    push_n(17);
    start_run(3'd0);
    obs_n(8);
    start_run(3'd2);
    for (int i = 8; i < 17; i++) obs_word(ow[i]);
    wait_idle("t6a_idle");
    check("t6a_run_checks", run_checks_o, 32'd16);
    push_n(17);
    start_run(3'd4);
    obs_n(17);
    wait_idle("t6b_idle");
    check("t6_tot_checks", tot_checks_o, 32'd32);
    check("t6_tot_hits", tot_hits_o, 32'd32);
    check("t6_flag_hits", flag_hits_o, 32'd2);
    check("t6_done_pulses", 32'(done_cnt - d0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
